// File: rtl/card_datapath_multi_if.sv
// card_datapath_multi_if: load requests from the game FSM and the card/score/result view back to it.
interface card_datapath_multi_if #(
    parameter int NUM_HANDS = 2,
    parameter int CARDS_PER_HAND = 3
);
    localparam int HW = $clog2(NUM_HANDS);
    localparam int SW = $clog2(CARDS_PER_HAND);
    logic load_en;
    logic [HW-1:0] load_hand;
    logic [SW-1:0] load_slot;
    logic [3:0] next_card;
    logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards;
    logic [NUM_HANDS*4-1:0] scores;
    logic [NUM_HANDS*4-1:0] card_count;
    logic [3:0] last_card;
    logic load_err;
    logic [HW-1:0] leader;
    logic tie;
    modport master (
        output load_en, load_hand, load_slot,
        input next_card, cards, scores, card_count, last_card, load_err, leader, tie
    );
    modport slave (
        input load_en, load_hand, load_slot,
        output next_card, cards, scores, card_count, last_card, load_err, leader, tie
    );
endinterface

// File: rtl/card_datapath_multi.sv
// card_datapath_multi: N-hand baccarat card store with on-chip dealer, registered scores and leader/tie.
// CARD_LFSR_EN swaps the 1..13 counter dealer for a 16-bit LFSR dealer.
module card_datapath_multi #(
    parameter int NUM_HANDS = 2,
    parameter int CARDS_PER_HAND = 3
) (
    input logic slow_clock,
    input logic resetb,
    card_datapath_multi_if.slave bus
);
    localparam int HW = $clog2(NUM_HANDS);
    localparam int SW = $clog2(CARDS_PER_HAND);
    logic [3:0] card [NUM_HANDS][CARDS_PER_HAND];
    logic [3:0] score [NUM_HANDS];
    logic [3:0] score_n [NUM_HANDS];
    logic [3:0] count [NUM_HANDS];
    logic [6:0] sum [NUM_HANDS];
    logic [3:0] next_card, last_card, best, ties;
    logic load_err, tie, tie_n, hit, full, accept;
    logic [HW-1:0] leader, leader_n;

    function automatic logic [3:0] face(input logic [3:0] c);
        return c > 4'd9 ? 4'd0 : c;
    endfunction

`ifdef CARD_LFSR_EN
    logic [15:0] lfsr;
    logic [3:0] lfsr_mod;
    assign lfsr_mod = 4'(lfsr % 16'd13);
    assign next_card = lfsr_mod + 4'd1;
    always_ff @(posedge slow_clock)
        lfsr <= resetb ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
    always_ff @(posedge slow_clock)
        next_card <= resetb || next_card == 4'd13 ? 4'd1 : next_card + 4'd1;
`endif

    // an index outside the hand/slot range never matches, so it is rejected like a filled slot
    always_comb begin
        hit = 1'b0;
        full = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++)
            for (int s = 0; s < CARDS_PER_HAND; s++)
                if (bus.load_hand == HW'(h) && bus.load_slot == SW'(s)) begin
                    hit = 1'b1;
                    full = card[h][s] != 4'd0;
                end
        accept = bus.load_en && hit && !full;
    end

    always_comb begin
        for (int h = 0; h < NUM_HANDS; h++) begin
            sum[h] = 7'd0;
            for (int s = 0; s < CARDS_PER_HAND; s++)
                sum[h] = sum[h] + 7'(face(card[h][s]));
            score_n[h] = 4'(sum[h] % 7'd10);
        end
    end

    // strict > keeps the lowest index among equal maxima
    always_comb begin
        leader_n = '0;
        best = score[0];
        ties = 4'd0;
        for (int h = 1; h < NUM_HANDS; h++)
            if (score[h] > best) begin
                best = score[h];
                leader_n = HW'(h);
            end
        for (int h = 0; h < NUM_HANDS; h++)
            ties = ties + {3'd0, score[h] == best};
        tie_n = ties > 4'd1;
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score[h] <= 4'd0;
                count[h] <= 4'd0;
                for (int s = 0; s < CARDS_PER_HAND; s++)
                    card[h][s] <= 4'd0;
            end
            last_card <= 4'd0;
            load_err <= 1'b0;
            leader <= '0;
            tie <= 1'b0;
        end else begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score[h] <= score_n[h];
                if (accept && bus.load_hand == HW'(h) && count[h] != 4'd15)
                    count[h] <= count[h] + 4'd1;
                for (int s = 0; s < CARDS_PER_HAND; s++)
                    if (accept && bus.load_hand == HW'(h) && bus.load_slot == SW'(s))
                        card[h][s] <= next_card;
            end
            if (accept)
                last_card <= next_card;
            load_err <= bus.load_en && !accept;
            leader <= leader_n;
            tie <= tie_n;
        end
    end

    for (genvar g = 0; g < NUM_HANDS; g++) begin : g_hand
        assign bus.scores[g*4 +: 4] = score[g];
        assign bus.card_count[g*4 +: 4] = count[g];
        for (genvar k = 0; k < CARDS_PER_HAND; k++) begin : g_slot
            assign bus.cards[(g*CARDS_PER_HAND+k)*4 +: 4] = card[g][k];
        end
    end

    assign bus.next_card = next_card;
    assign bus.last_card = last_card;
    assign bus.load_err = load_err;
    assign bus.leader = leader;
    assign bus.tie = tie;
endmodule

// File: tb/tb_card_datapath_multi.sv
// tb_card_datapath_multi: directed and random checks of three card_datapath_multi builds against a behavioural model.
module tb_card_datapath_multi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic [7:0] hand = '0;
    logic [7:0] slot = '0;
    int sel = 0;
    int nh = 2, nc = 3, hmax = 1, smax = 3;
    int errors = 0, checks = 0;
    int mc [8][8];
    int ms [8];
    int mcnt [8];
    int mlast, merr, mlead, mtie, mdeal;
    logic [255:0] o_cards;
    logic [31:0] o_scores, o_cnt;
    logic [3:0] o_next, o_last;
    logic [2:0] o_lead;
    logic o_err, o_tie;

    always #5 clk = ~clk;

    card_datapath_multi_if #(.NUM_HANDS(2), .CARDS_PER_HAND(3)) if0 ();
    card_datapath_multi_if #(.NUM_HANDS(4), .CARDS_PER_HAND(4)) if1 ();
    card_datapath_multi_if #(.NUM_HANDS(3), .CARDS_PER_HAND(2)) if2 ();

    card_datapath_multi #(.NUM_HANDS(2), .CARDS_PER_HAND(3)) u0 (.slow_clock(clk), .resetb(rst), .bus(if0));
    card_datapath_multi #(.NUM_HANDS(4), .CARDS_PER_HAND(4)) u1 (.slow_clock(clk), .resetb(rst), .bus(if1));
    card_datapath_multi #(.NUM_HANDS(3), .CARDS_PER_HAND(2)) u2 (.slow_clock(clk), .resetb(rst), .bus(if2));

    assign if0.load_en = en && sel == 0;
    assign if0.load_hand = hand[0:0];
    assign if0.load_slot = slot[1:0];
    assign if1.load_en = en && sel == 1;
    assign if1.load_hand = hand[1:0];
    assign if1.load_slot = slot[1:0];
    assign if2.load_en = en && sel == 2;
    assign if2.load_hand = hand[1:0];
    assign if2.load_slot = slot[0:0];

    always_comb begin
        o_cards = 256'(if0.cards);
        o_scores = 32'(if0.scores);
        o_cnt = 32'(if0.card_count);
        o_next = if0.next_card;
        o_last = if0.last_card;
        o_lead = 3'(if0.leader);
        o_err = if0.load_err;
        o_tie = if0.tie;
        if (sel == 1) begin
            o_cards = 256'(if1.cards);
            o_scores = 32'(if1.scores);
            o_cnt = 32'(if1.card_count);
            o_next = if1.next_card;
            o_last = if1.last_card;
            o_lead = 3'(if1.leader);
            o_err = if1.load_err;
            o_tie = if1.tie;
        end else if (sel == 2) begin
            o_cards = 256'(if2.cards);
            o_scores = 32'(if2.scores);
            o_cnt = 32'(if2.card_count);
            o_next = if2.next_card;
            o_last = if2.last_card;
            o_lead = 3'(if2.leader);
            o_err = if2.load_err;
            o_tie = if2.tie;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge of the game rules, applied to the model's pre-edge state
    task automatic model(input logic r, input logic e, input int h, input int s);
        int mx, nl, nt, total;
        int ns [8];
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                ms[i] = 0;
                mcnt[i] = 0;
                for (int j = 0; j < 8; j++) mc[i][j] = 0;
            end
            mlast = 0; merr = 0; mlead = 0; mtie = 0; mdeal = 1;
            return;
        end
        mx = -1; nl = 0; nt = 0;
        for (int i = 0; i < nh; i++) if (ms[i] > mx) begin mx = ms[i]; nl = i; end
        for (int i = 0; i < nh; i++) if (ms[i] == mx && i != nl) nt = 1;
        for (int i = 0; i < nh; i++) begin
            total = 0;
            for (int j = 0; j < nc; j++) total += (mc[i][j] > 9) ? 0 : mc[i][j];
            ns[i] = total % 10;
        end
        merr = 0;
        if (e) begin
            if (h < nh && s < nc && mc[h][s] == 0) begin
                mc[h][s] = mdeal;
                mlast = mdeal;
                if (mcnt[h] < 15) mcnt[h]++;
            end else merr = 1;
        end
        for (int i = 0; i < nh; i++) ms[i] = ns[i];
        mlead = nl; mtie = nt;
        mdeal = mdeal % 13 + 1;
    endtask

    task automatic check_all();
        logic [255:0] xc;
        logic [31:0] xs, xn;
        xc = '0; xs = '0; xn = '0;
        for (int h = 0; h < nh; h++) begin
            xs[h*4 +: 4] = 4'(ms[h]);
            xn[h*4 +: 4] = 4'(mcnt[h]);
            for (int s = 0; s < nc; s++) xc[(h*nc+s)*4 +: 4] = 4'(mc[h][s]);
        end
        chk("cards", o_cards, xc);
        chk("scores", 256'(o_scores), 256'(xs));
        chk("card_count", 256'(o_cnt), 256'(xn));
        chk("next_card", 256'(o_next), 256'(mdeal));
        chk("last_card", 256'(o_last), 256'(mlast));
        chk("load_err", 256'(o_err), 256'(merr));
        chk("leader", 256'(o_lead), 256'(mlead));
        chk("tie", 256'(o_tie), 256'(mtie));
    endtask

    task automatic tick(input logic r, input logic e, input int h, input int s);
        rst = r; en = e; hand = 8'(h); slot = 8'(s);
        @(posedge clk);
        model(r, e, h, s);
        #1;
        check_all();
    endtask

    task automatic load_when(input int v, input int h, input int s);
        for (int i = 0; i < 14 && mdeal != v; i++) tick(0, 0, 0, 0);
        chk("dealer_ready", 256'(o_next), 256'(v));
        tick(0, 1, h, s);
    endtask

    task automatic use_dut(input int d);
        sel = d;
        nh = d == 0 ? 2 : d == 1 ? 4 : 3;
        nc = d == 0 ? 3 : d == 1 ? 4 : 2;
        hmax = d == 0 ? 1 : 3;
        smax = d == 2 ? 1 : 3;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
    endtask

    initial begin
        use_dut(0);
        chk("reset_cards", o_cards, '0);
        chk("reset_next", 256'(o_next), 256'(1));
        tick(0, 0, 0, 0);
        chk("tie_after_reset", 256'(o_tie), 256'(1));
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
        chk("dealer_wrap", 256'(o_next), 256'(1));
        load_when(7, 0, 0);
        chk("single_card", o_cards[3:0], 256'(7));
        chk("single_last", 256'(o_last), 256'(7));
        chk("single_count", o_cnt[3:0], 256'(1));
        tick(0, 0, 0, 0);
        chk("single_score", o_scores[3:0], 256'(7));
        tick(0, 0, 0, 0);
        chk("single_leader", 256'(o_lead), 256'(0));
        chk("single_tie", 256'(o_tie), 256'(0));
        load_when(9, 1, 0);
        load_when(8, 1, 1);
        tick(0, 0, 0, 0);
        chk("mod10_score", o_scores[7:4], 256'(7));
        load_when(12, 1, 2);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("face_score", o_scores[7:4], 256'(7));
        chk("eq_tie", 256'(o_tie), 256'(1));
        chk("eq_leader", 256'(o_lead), 256'(0));
        tick(0, 1, 1, 0);
        chk("rej_full_err", 256'(o_err), 256'(1));
        chk("rej_full_keep", o_cards[15:12], 256'(9));
        chk("rej_full_count", o_cnt[7:4], 256'(3));
        tick(0, 0, 0, 0);
        chk("err_clears", 256'(o_err), 256'(0));
        tick(0, 1, 0, 3);
        chk("rej_slot_err", 256'(o_err), 256'(1));
        tick(1, 1, 0, 1);
        chk("midreset_cards", o_cards, '0);
        chk("midreset_next", 256'(o_next), 256'(1));
        chk("midreset_err", 256'(o_err), 256'(0));

        use_dut(1);
        load_when(3, 0, 0);
        load_when(5, 3, 0);
        load_when(5, 3, 1);
        load_when(5, 3, 2);
        load_when(4, 3, 3);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("p4_score", o_scores[15:12], 256'(9));
        chk("p4_leader", 256'(o_lead), 256'(3));
        chk("p4_tie", 256'(o_tie), 256'(0));

        use_dut(2);
        tick(0, 1, 3, 0);
        chk("rej_hand_err", 256'(o_err), 256'(1));
        chk("rej_hand_count", 256'(o_cnt), '0);

        for (int d = 0; d < 3; d++) begin
            use_dut(d);
            for (int i = 0; i < 250; i++)
                tick($urandom % 40 == 0, 1'($urandom), int'($urandom_range(0, hmax)), int'($urandom_range(0, smax)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
